// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command scheduler: opcodes, keyboard
// response codes, error codes, FSM state encoding and a small helper.
package ps2_pkg;

  localparam logic [7:0] OP_RESET   = 8'hFF;
  localparam logic [7:0] OP_LED     = 8'hED;
  localparam logic [7:0] OP_RATE    = 8'hF3;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT    = 8'hAA;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RETRY   = 2'b10;
  localparam logic [1:0] ERR_TX      = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP,
    ST_SEND_ARG,
    ST_WAIT_SENT,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Saturating up-counter: expired is high once count reaches limit-1 and the
// counter holds there until cleared.
module ps2_timeout_timer #(
  parameter int WIDTH = 8
) (
  input  logic             inclock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  assign expired = (count_reg == (limit - WIDTH'(1)));

  // Count while enabled, stopping at the expiry value instead of wrapping.
  always_ff @(posedge inclock or posedge reset) begin
    if (reset)
      count_reg <= '0;
    else if (clear)
      count_reg <= '0;
    else if (enable && !expired)
      count_reg <= count_reg + WIDTH'(1);
  end

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// Host-to-keyboard command sequencer: arbitrates reset/LED/rate requests,
// sends opcode and argument bytes, consumes ACK/RESEND/BAT responses and
// forwards every other received byte to the scan-code path.
// Build option: define PS2_CMD_RETRY_EN to retry a byte on RESEND up to
// MAX_RETRY times; otherwise the first RESEND aborts the command.
module ps2_cmd_scheduler
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT = 50000,
  parameter int BAT_TIMEOUT = 50000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       inclock,
  input  logic       reset,
  input  logic       req_reset,
  input  logic       req_led,
  input  logic       req_rate,
  input  logic [2:0] led_state,
  input  logic [7:0] rate_arg,
  output logic [2:0] grant,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] cmd_data,
  output logic       cmd_send,
  input  logic       cmd_sent,
  input  logic       cmd_tx_err,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] key_data,
  output logic       key_valid
);

  localparam int TW = $clog2(max_int(ACK_TIMEOUT, BAT_TIMEOUT)) + 1;

  state_t     state_reg, state_next;
  logic [2:0] grant_reg, grant_next;
  logic [7:0] cmd_data_reg, cmd_data_next;
  logic [7:0] arg_reg, arg_next;
  logic       arg_phase_reg, arg_phase_next;
  logic [1:0] err_code_reg, err_code_next;
  logic [7:0] key_data_reg;
  logic       key_valid_reg;
  logic       absorb;
  logic       timer_clear, timer_enable, timer_expired;
  logic [TW-1:0] timer_limit;

  logic rx_ack, rx_resend, rx_bat, has_arg;
  assign rx_ack    = rx_valid && (rx_data == RSP_ACK);
  assign rx_resend = rx_valid && (rx_data == RSP_RESEND);
  assign rx_bat    = rx_valid && (rx_data == RSP_BAT);
  assign has_arg   = grant_reg[1] | grant_reg[2];

`ifdef PS2_CMD_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_reg, retry_next;
`endif

  // The timer restarts whenever a response wait begins, including the
  // hand-over from the reset-command ACK to the BAT wait.
  assign timer_enable = (state_reg == ST_WAIT_ACK) || (state_reg == ST_WAIT_BAT);
  assign timer_clear  = !timer_enable ||
                        ((state_reg == ST_WAIT_ACK) && (state_next == ST_WAIT_BAT));
  assign timer_limit  = (state_reg == ST_WAIT_BAT) ? TW'(BAT_TIMEOUT) : TW'(ACK_TIMEOUT);

  ps2_timeout_timer #(.WIDTH(TW)) u_timer (
    .inclock (inclock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

  // State and command-context registers.
  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      cmd_data_reg  <= '0;
      arg_reg       <= '0;
      arg_phase_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
`ifdef PS2_CMD_RETRY_EN
      retry_reg     <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      cmd_data_reg  <= cmd_data_next;
      arg_reg       <= arg_next;
      arg_phase_reg <= arg_phase_next;
      err_code_reg  <= err_code_next;
`ifdef PS2_CMD_RETRY_EN
      retry_reg     <= retry_next;
`endif
    end
  end

  // Next-state logic: arbitration, byte sequencing and response handling.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    cmd_data_next  = cmd_data_reg;
    arg_next       = arg_reg;
    arg_phase_next = arg_phase_reg;
    err_code_next  = err_code_reg;
    absorb         = 1'b0;
`ifdef PS2_CMD_RETRY_EN
    retry_next     = retry_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (req_reset || req_led || req_rate) begin
          state_next     = ST_SEND_OP;
          arg_phase_next = 1'b0;
`ifdef PS2_CMD_RETRY_EN
          retry_next     = '0;
`endif
          if (req_reset) begin
            grant_next    = 3'b001;
            cmd_data_next = OP_RESET;
            arg_next      = 8'h00;
          end else if (req_led) begin
            grant_next    = 3'b010;
            cmd_data_next = OP_LED;
            arg_next      = {5'b0, led_state};
          end else begin
            grant_next    = 3'b100;
            cmd_data_next = OP_RATE;
            arg_next      = rate_arg;
          end
        end
      end
      ST_SEND_OP, ST_SEND_ARG: state_next = ST_WAIT_SENT;
      ST_WAIT_SENT: begin
        if (cmd_tx_err) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TX;
        end else if (cmd_sent) begin
          state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (rx_ack) begin
          absorb = 1'b1;
          if (!arg_phase_reg && has_arg) begin
            state_next     = ST_SEND_ARG;
            arg_phase_next = 1'b1;
            cmd_data_next  = arg_reg;
`ifdef PS2_CMD_RETRY_EN
            retry_next     = '0;
`endif
          end else if (grant_reg[0]) begin
            state_next = ST_WAIT_BAT;
          end else begin
            state_next = ST_DONE;
          end
        end else if (rx_resend) begin
          absorb = 1'b1;
`ifdef PS2_CMD_RETRY_EN
          if (retry_reg < RW'(MAX_RETRY)) begin
            retry_next = retry_reg + RW'(1);
            state_next = arg_phase_reg ? ST_SEND_ARG : ST_SEND_OP;
          end else begin
            state_next    = ST_ERR;
            err_code_next = ERR_RETRY;
          end
`else
          state_next    = ST_ERR;
          err_code_next = ERR_RETRY;
`endif
        end else if (timer_expired && !rx_valid) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TIMEOUT;
        end
      end
      ST_WAIT_BAT: begin
        if (rx_bat) begin
          absorb     = 1'b1;
          state_next = ST_DONE;
        end else if (timer_expired && !rx_valid) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TIMEOUT;
        end
      end
      ST_DONE, ST_ERR: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Forward every received byte the sequencer does not consume, one cycle late.
  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      key_valid_reg <= 1'b0;
      key_data_reg  <= '0;
    end else begin
      key_valid_reg <= rx_valid && !absorb;
      if (rx_valid && !absorb)
        key_data_reg <= rx_data;
    end
  end

  assign grant     = grant_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign err       = (state_reg == ST_ERR);
  assign err_code  = err_code_reg;
  assign cmd_data  = cmd_data_reg;
  assign cmd_send  = (state_reg == ST_SEND_OP) || (state_reg == ST_SEND_ARG);
  assign key_data  = key_data_reg;
  assign key_valid = key_valid_reg;

endmodule
